max_pool_unit: RTL and testbench

Streaming 1-D max-pooling stage that consumes the thresholded 8-bit samples leaving the activation unit. It reduces each window of POOL consecutive samples to its maximum and buffers the results in a small output FIFO. Valid/ready handshakes on both sides decouple it from the next layer. A frame-end marker closes a partial window early.

---
 rtl/max_pool_pkg.sv | 25 ++
 rtl/max_pool_unit_if.sv | 27 ++
 rtl/max_pool_unit_pool_fifo.sv | 78 +++++++
 rtl/max_pool_unit.sv | 74 +++++++
 tb/tb_max_pool_unit.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/max_pool_pkg.sv
// Shared parameters, state encoding and helpers for the max_pool_unit slice.
// DATA_W     : sample width (unsigned)
// POOL       : samples reduced per window
// FIFO_DEPTH : output FIFO entries (power of two)
package max_pool_pkg;

   localparam int DATA_W     = 8;
   localparam int POOL       = 4;
   localparam int FIFO_DEPTH = 4;

   localparam int CNT_W = $clog2(POOL);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } pool_state_t;

   function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      return (a >= b) ? a : b;
   endfunction

endpackage

// File: rtl/max_pool_unit_if.sv
// Streaming handshake bundle for max_pool_unit.
// slave  : pooling block side (consumes in_*, produces out_*/status)
// master : upstream/downstream side (drives in_*, out_ready)
interface max_pool_unit_if;
   import max_pool_pkg::*;

   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic [LVL_W-1:0]  fifo_level;
   logic              busy;

   modport slave (
      input  in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, fifo_level, busy
   );

   modport master (
      output in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, fifo_level, busy
   );

endinterface

// File: rtl/max_pool_unit_pool_fifo.sv
// Synchronous output FIFO with a registered head-data register.
// clk, rst   : clock, async active-low reset
// i_wr/i_wr_data : push request and data (ignored when full)
// i_rd       : pop request (ignored when empty)
// o_full/o_empty/o_level : occupancy status, all from registered level
// o_head     : registered copy of the oldest entry
module pool_fifo
   import max_pool_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_wr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic              i_rd,
   output logic              o_full,
   output logic              o_empty,
   output logic [LVL_W-1:0]  o_level,
   output logic [DATA_W-1:0] o_head
);

   logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [LVL_W-1:0]  r_level;
   logic [DATA_W-1:0] r_head;
   logic              w_wr;
   logic              w_rd;
   logic [PTR_W-1:0]  w_rd_ptr_nxt;

   assign o_full       = (r_level == LVL_W'(FIFO_DEPTH));
   assign o_empty      = (r_level == '0);
   assign o_level      = r_level;
   assign o_head       = r_head;
   assign w_wr         = i_wr & ~o_full;
   assign w_rd         = i_rd & ~o_empty;
   assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_head   <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         case ({w_wr, w_rd})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         // Head tracks the oldest entry. When the only entry is popped while a
         // new one is pushed, the successor is still in flight on i_wr_data.
         if (w_rd) begin
            if (r_level == LVL_W'(1)) begin
               if (w_wr) begin
                  r_head <= i_wr_data;
               end
            end else begin
               r_head <= r_mem[w_rd_ptr_nxt];
            end
         end else if (w_wr && o_empty) begin
            r_head <= i_wr_data;
         end
      end
   end

endmodule

// File: rtl/max_pool_unit.sv
// Streaming 1-D max-pooling stage: reduces each POOL-sample window (or a
// shorter window closed by in_last) to its unsigned maximum and queues the
// results in a small output FIFO.
// clk, rst : clock, async active-low reset
// bus      : max_pool_unit_if.slave (in_* stream, out_* stream, fifo_level, busy)
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no window open, next accepted sample starts one
// ST_ACCUM | window open, r_cur_max holds its running maximum
module max_pool_unit
   import max_pool_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   max_pool_unit_if.slave bus
);

   pool_state_t       r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_cur_max;
   logic              r_busy;

   logic              w_full;
   logic              w_empty;
   logic              w_accept;
   logic              w_close;
   logic              w_pop;
   logic [DATA_W-1:0] w_push_data;

   // Ready depends only on FIFO occupancy so no input reaches an output.
   assign bus.in_ready  = ~w_full;
   assign bus.out_valid = ~w_empty;
   assign bus.busy      = r_busy;

   assign w_accept    = bus.in_valid & ~w_full;
   assign w_close     = w_accept & ((r_cnt == CNT_W'(POOL - 1)) | bus.in_last);
   assign w_pop       = ~w_empty & bus.out_ready;
   assign w_push_data = (r_state == ST_IDLE) ? bus.in_data
                                             : max_u(r_cur_max, bus.in_data);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_cur_max <= '0;
         r_busy    <= 1'b0;
      end else if (w_accept) begin
         r_cur_max <= w_push_data;
         if (w_close) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
         end else begin
            r_state <= ST_ACCUM;
            r_cnt   <= r_cnt + 1'b1;
            r_busy  <= 1'b1;
         end
      end
   end

   pool_fifo u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_wr      (w_close),
      .i_wr_data (w_push_data),
      .i_rd      (w_pop),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_level   (bus.fifo_level),
      .o_head    (bus.out_data)
   );

endmodule

// File: tb/tb_max_pool_unit.sv
module tb_max_pool_unit;
   import max_pool_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] mon_exp;

   max_pool_unit_if bus();

   max_pool_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Scoreboard monitor: a transfer happens at the next rising edge when
   // out_valid & out_ready are seen here.
   always @(negedge clk) begin
      if (rst && bus.out_valid && bus.out_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_output", int'(bus.out_data), -1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_out_data", int'(bus.out_data), int'(mon_exp));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int d, input bit last);
      int  n;
      bit  rdy;
      logic [31:0] dv;
      n  = 0;
      dv = d;
      bus.in_data  = dv[DATA_W-1:0];
      bus.in_valid = 1'b1;
      bus.in_last  = last;
      forever begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         #1;
         if (rdy) break;
         n++;
         if (n > 200) begin
            check("send_timeout", 0, 1);
            break;
         end
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         if (exp_q.size() == 0 && !bus.out_valid) break;
         tick();
      end
      check("drain_out_valid", int'(bus.out_valid), 0);
      check("drain_sb_left", exp_q.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int v4 [20];
      v4 = '{1, 9, 3, 2, 50, 60, 70, 80, 255, 0, 0, 0, 7, 7, 7, 7, 4, 100, 99, 5};

      bus.in_data   = '0;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      #1 rst = 1'b0;
      #11;
      check("rst_out_valid",  int'(bus.out_valid), 0);
      check("rst_out_data",   int'(bus.out_data), 0);
      check("rst_fifo_level", int'(bus.fifo_level), 0);
      check("rst_busy",       int'(bus.busy), 0);
      check("rst_in_ready",   int'(bus.in_ready), 1);
      tick();
      rst = 1'b1;
      tick();

      // full windows, out_ready high
      bus.out_ready = 1'b1;
      exp_q.push_back(8'd40);
      exp_q.push_back(8'd10);
      send(3, 0);
      check("t1_busy_open", int'(bus.busy), 1);
      send(12, 0);
      send(7, 0);
      check("t1_no_early_valid", int'(bus.out_valid), 0);
      send(40, 0);
      check("t1_valid_after_4th", int'(bus.out_valid), 1);
      check("t1_data_40", int'(bus.out_data), 40);
      check("t1_busy_closed", int'(bus.busy), 0);
      check("t1_level_1", int'(bus.fifo_level), 1);
      send(0, 0);
      check("t1_level_after_pop", int'(bus.fifo_level), 0);
      check("t1_busy_second", int'(bus.busy), 1);
      send(10, 0);
      send(10, 0);
      send(9, 0);
      check("t1_valid_after_8th", int'(bus.out_valid), 1);
      check("t1_data_10", int'(bus.out_data), 10);
      wait_drain();

      // in_last closes a partial window
      exp_q.push_back(8'd200);
      send(5, 0);
      send(200, 0);
      send(17, 1);
      check("t2_valid", int'(bus.out_valid), 1);
      check("t2_data_200", int'(bus.out_data), 200);
      check("t2_busy", int'(bus.busy), 0);
      wait_drain();

      // in_last on the first sample of a window
      bus.out_ready = 1'b0;
      exp_q.push_back(8'd33);
      send(33, 1);
      check("t3_level_1", int'(bus.fifo_level), 1);
      check("t3_data_33", int'(bus.out_data), 33);
      check("t3_busy", int'(bus.busy), 0);
      tick();
      check("t3_hold_level", int'(bus.fifo_level), 1);
      check("t3_hold_data", int'(bus.out_data), 33);
      bus.out_ready = 1'b1;
      wait_drain();

      // fill the FIFO, stall input, then drain
      bus.out_ready = 1'b0;
      exp_q.push_back(8'd9);
      exp_q.push_back(8'd80);
      exp_q.push_back(8'd255);
      exp_q.push_back(8'd7);
      exp_q.push_back(8'd100);
      for (int i = 0; i < 16; i++) send(v4[i], 0);
      check("t4_level_full", int'(bus.fifo_level), 4);
      check("t4_in_ready_low", int'(bus.in_ready), 0);
      check("t4_head_9", int'(bus.out_data), 9);
      fork
         begin
            for (int i = 16; i < 20; i++) send(v4[i], 0);
         end
         begin
            tick();
            tick();
            tick();
            check("t4_stalled_busy", int'(bus.busy), 0);
            check("t4_stalled_level", int'(bus.fifo_level), 4);
            bus.out_ready = 1'b1;
            tick();
            check("t4_in_ready_back", int'(bus.in_ready), 1);
            check("t4_level_3", int'(bus.fifo_level), 3);
            check("t4_head_80", int'(bus.out_data), 80);
         end
      join
      wait_drain();

      // simultaneous push and pop at level 2
      bus.out_ready = 1'b0;
      exp_q.push_back(8'd11);
      exp_q.push_back(8'd22);
      exp_q.push_back(8'd33);
      send(11, 1);
      send(22, 1);
      check("t5_level_2", int'(bus.fifo_level), 2);
      bus.out_ready = 1'b1;
      send(33, 1);
      check("t5_level_same", int'(bus.fifo_level), 2);
      check("t5_head_22", int'(bus.out_data), 22);
      bus.out_ready = 1'b0;
      tick();
      check("t5_stable_22", int'(bus.out_data), 22);
      check("t5_stable_level", int'(bus.fifo_level), 2);
      bus.out_ready = 1'b1;
      wait_drain();

      // reset mid-window with a partly full FIFO
      bus.out_ready = 1'b0;
      send(61, 1);
      send(62, 1);
      send(63, 1);
      send(70, 0);
      send(71, 0);
      check("t6_pre_level", int'(bus.fifo_level), 3);
      check("t6_pre_busy", int'(bus.busy), 1);
      rst = 1'b0;
      #1;
      check("t6_rst_out_valid", int'(bus.out_valid), 0);
      check("t6_rst_out_data", int'(bus.out_data), 0);
      check("t6_rst_level", int'(bus.fifo_level), 0);
      check("t6_rst_busy", int'(bus.busy), 0);
      check("t6_rst_in_ready", int'(bus.in_ready), 1);
      bus.in_data  = 8'd200;
      bus.in_valid = 1'b1;
      bus.in_last  = 1'b1;
      tick();
      tick();
      check("t6_inputs_ignored", int'(bus.fifo_level), 0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      check("t6_no_output_after_release", int'(bus.out_valid), 0);
      bus.out_ready = 1'b1;
      exp_q.push_back(8'd4);
      send(1, 0);
      send(2, 0);
      send(3, 0);
      check("t6_no_early_valid", int'(bus.out_valid), 0);
      check("t6_busy", int'(bus.busy), 1);
      send(4, 0);
      check("t6_valid", int'(bus.out_valid), 1);
      check("t6_data_4", int'(bus.out_data), 4);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
